// File: rtl/bitwise_stats_pkg.sv
// Shared constants and types for the bitwise result statistics stage.
// Lane numbering follows the Bitwise_operations outputs: lane 0 is out1.
package bitwise_stats_pkg;

    localparam int NUM_LANES = 5;

    localparam int LANE_OUT1 = 0;
    localparam int LANE_OUT2 = 1;
    localparam int LANE_OUT3 = 2;
    localparam int LANE_OUT4 = 3;
    localparam int LANE_OUT5 = 4;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Width needed to hold a count in 0..window.
    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/bitwise_lane_counter.sv
// One lane: window accumulator plus held result snapshot.
// With BWSTAT_TOGGLE_EN defined it also counts toggles against the previous accepted sample.
module bitwise_lane_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             complete,
    input  logic             bit_in,
    output logic [CNT_W-1:0] cnt_out
`ifdef BWSTAT_TOGGLE_EN
    ,
    output logic [CNT_W-1:0] tog_out
`endif
);

    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0] acc_inc;

    // The completing sample is folded into the snapshot, never into the next window.
    always_comb begin
        acc_inc = acc_q + CNT_W'(bit_in);
        acc_d   = acc_q;
        snap_d  = snap_q;
        if (accept) begin
            acc_d = complete ? '0 : acc_inc;
        end
        if (complete) begin
            snap_d = acc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            snap_q <= '0;
        end else begin
            acc_q  <= acc_d;
            snap_q <= snap_d;
        end
    end

    assign cnt_out = snap_q;

`ifdef BWSTAT_TOGGLE_EN
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] tog_q, tog_d;
    logic [CNT_W-1:0] tog_snap_q, tog_snap_d;
    logic [CNT_W-1:0] tog_inc;

    // prev persists across window boundaries; only reset clears it.
    always_comb begin
        tog_inc    = tog_q + CNT_W'(bit_in ^ prev_q);
        prev_d     = prev_q;
        tog_d      = tog_q;
        tog_snap_d = tog_snap_q;
        if (accept) begin
            prev_d = bit_in;
            tog_d  = complete ? '0 : tog_inc;
        end
        if (complete) begin
            tog_snap_d = tog_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= 1'b0;
            tog_q      <= '0;
            tog_snap_q <= '0;
        end else begin
            prev_q     <= prev_d;
            tog_q      <= tog_d;
            tog_snap_q <= tog_snap_d;
        end
    end

    assign tog_out = tog_snap_q;
`endif

endmodule

// File: rtl/bitwise_result_stats.sv
// Windowed per-lane high counts for the five Bitwise_operations results, double-buffered.
// Optional per-lane toggle counts are built when BWSTAT_TOGGLE_EN is defined.
module bitwise_result_stats
    import bitwise_stats_pkg::*;
#(
    parameter int WINDOW = 16,
    localparam int CNT_W = cnt_width(WINDOW)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES-1:0]       in_bits,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_LANES*CNT_W-1:0] cnt_bus
`ifdef BWSTAT_TOGGLE_EN
    ,
    output logic [NUM_LANES*CNT_W-1:0] tog_bus
`endif
);

    localparam int SAMP_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(WINDOW - 1);

    buf_state_e        state_q, state_d;
    logic [SAMP_W-1:0] samp_q, samp_d;
    logic              last_samp;
    logic              accept;
    logic              complete;

    assign last_samp = (samp_q == SAMP_LAST);
    assign out_valid = (state_q == BUF_FULL);

    // Stall only the completing sample, and only while the held result is not being taken.
    assign in_ready = !(out_valid && !out_ready && last_samp);
    assign accept   = in_valid && in_ready;
    assign complete = accept && last_samp;

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        if (accept) begin
            samp_d = last_samp ? '0 : samp_q + SAMP_W'(1);
        end
        case (state_q)
            BUF_EMPTY: if (complete) state_d = BUF_FULL;
            BUF_FULL:  if (out_ready && !complete) state_d = BUF_EMPTY;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            samp_q  <= '0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            bitwise_lane_counter #(
                .CNT_W(CNT_W)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .accept  (accept),
                .complete(complete),
                .bit_in  (in_bits[gi]),
                .cnt_out (cnt_bus[gi*CNT_W +: CNT_W])
`ifdef BWSTAT_TOGGLE_EN
                ,
                .tog_out (tog_bus[gi*CNT_W +: CNT_W])
`endif
            );
        end
    endgenerate

endmodule
